// File: rtl/note_spawner_if.sv
// Note delivery channel between the spawner and the note-scroll renderer.
// Zero latency: wires only.
// A note is transferred on any cycle where note_valid and note_ready are both high.
interface note_spawner_if #(
   parameter int LANES = 5
);
   logic             note_valid;
   logic             note_ready;
   logic [LANES-1:0] note_lanes;

   modport master (output note_valid, output note_lanes, input note_ready);
   modport slave  (input note_valid, input note_lanes, output note_ready);
endinterface

// File: rtl/note_spawner.sv
// Random fret-lane note generator driven by a free-running Fibonacci LFSR.
// Latency: a spawn tick presents its note on the next clock edge.
// Backpressure: one-entry output register; a note that cannot load is dropped and counted.
module note_spawner #(
   parameter int                LANES  = 5,
   parameter int                LFSR_W = 13,
   parameter logic [LFSR_W-1:0] TAPS   = 13'h100D,
   parameter logic [LFSR_W-1:0] SEED   = 13'h0001,
   parameter int                CNT_W  = 16
) (
   input  logic                Clk,
   input  logic                RESET,
   input  logic                enable,
   input  logic                seed_load,
   input  logic [LFSR_W-1:0]   seed,
   input  logic                spawn_tick,
   input  logic [1:0]          mode,
   input  logic [7:0]          density,
   note_spawner_if.master      out_bus,
   output logic [CNT_W-1:0]    note_count,
   output logic [CNT_W-1:0]    drop_count,
   output logic [LFSR_W-1:0]   lfsr_state
);

   localparam int IDX_W = $clog2(LANES);
   // One extra bit so lane indices and LANES itself compare without overflow.
   localparam logic [IDX_W:0] LANES_V = (IDX_W+1)'(LANES);
   localparam logic [IDX_W:0] ONE_V   = (IDX_W+1)'(1);

   logic [LFSR_W-1:0] lfsr;
   logic              fb;
   logic [IDX_W:0]    idx;
   logic [7:0]        gate;
   logic              density_ok;

   logic [IDX_W:0]    sel_a;
   logic [IDX_W:0]    sel_b;
   logic              use_a;
   logic              use_b;
   logic [LANES-1:0]  cand;

   logic              produce;
   logic              accept;
   logic              load;
   logic              drop;

   logic              valid_q;
   logic [LANES-1:0]  lanes_q;

   assign fb         = ^(lfsr & TAPS);
   assign idx        = {1'b0, lfsr[IDX_W-1:0]};
   assign gate       = lfsr[LFSR_W-1 -: 8];
   assign density_ok = (density == 8'hFF) || (gate < density);

   // LFSR: seed load wins over advance; a zero seed would lock the LFSR, so substitute SEED.
   always_ff @(posedge Clk or negedge RESET) begin
      if (!RESET) begin
         lfsr <= SEED;
      end else if (seed_load) begin
         lfsr <= (seed == '0) ? SEED : seed;
      end else if (enable) begin
         lfsr <= {lfsr[LFSR_W-2:0], fb};
      end
   end

   // Lane mapping from the pre-update LFSR index; an all-zero result means a rest.
   always_comb begin
      use_a = 1'b0;
      use_b = 1'b0;
      sel_a = '0;
      sel_b = '0;
      cand  = '0;
      case (mode)
         2'b01: begin
            if (idx < LANES_V) begin
               use_a = 1'b1;
               use_b = 1'b1;
               sel_a = idx;
               sel_b = (idx == LANES_V - ONE_V) ? '0 : idx + ONE_V;
            end
         end
         2'b10: begin
            // Out-of-range indices fold back into the lane range so this mode never rests.
            use_a = 1'b1;
            sel_a = (idx >= LANES_V) ? idx - LANES_V : idx;
         end
         default: begin
            if (idx < LANES_V) begin
               use_a = 1'b1;
               sel_a = idx;
            end
         end
      endcase
      for (int i = 0; i < LANES; i++) begin
         cand[i] = (use_a && (sel_a == (IDX_W+1)'(i))) ||
                   (use_b && (sel_b == (IDX_W+1)'(i)));
      end
   end

   assign produce = spawn_tick && enable && density_ok && (cand != '0);
   assign accept  = valid_q && out_bus.note_ready;
   assign load    = produce && (!valid_q || out_bus.note_ready);
   assign drop    = produce && !load;

   // Output register: a new note takes priority over clearing after an accept.
   always_ff @(posedge Clk or negedge RESET) begin
      if (!RESET) begin
         valid_q <= 1'b0;
         lanes_q <= '0;
      end else if (load) begin
         valid_q <= 1'b1;
         lanes_q <= cand;
      end else if (accept) begin
         valid_q <= 1'b0;
         lanes_q <= '0;
      end
   end

   // Saturating statistics counters for delivered and dropped notes.
   always_ff @(posedge Clk or negedge RESET) begin
      if (!RESET) begin
         note_count <= '0;
         drop_count <= '0;
      end else begin
         if (accept && (note_count != '1)) begin
            note_count <= note_count + CNT_W'(1);
         end
         if (drop && (drop_count != '1)) begin
            drop_count <= drop_count + CNT_W'(1);
         end
      end
   end

   assign out_bus.note_valid = valid_q;
   assign out_bus.note_lanes = lanes_q;
   assign lfsr_state         = lfsr;

endmodule

// File: doc/note_spawner.md
Name: note_spawner

Overview:
Parametrised note-lane generator for the gameplay path. A free-running LFSR chooses which fret lanes light up on each spawn tick. The block adds single, folded and two-lane chord modes, a density gate, and seed loading. Notes are delivered through a valid/ready output register with drop accounting. It sits between the beat/tempo tick source and the note-scroll renderer.

Parameters:
LANES, 5, number of fret lanes (>= 2)
LFSR_W, 13, LFSR width (>= 8 and >= IDX_W)
TAPS, 13'h100D, feedback tap mask (bit i set = lfsr[i] feeds XOR)
SEED, 13'h0001, reset and zero-substitute seed (must be nonzero)
CNT_W, 16, statistics counter width
(derived) IDX_W = $clog2(LANES)

Ports:
Clk  in  1  system clock; sole clock, all logic rising-edge
RESET  in  1  asynchronous, active-low reset
enable  in  1  1 = run LFSR and accept ticks
seed_load  in  1  load seed into LFSR this cycle
seed  in  LFSR_W  seed value
spawn_tick  in  1  one-cycle strobe, Clk domain; request a note
mode  in  2  00 single, 01 chord2, 10 folded single, 11 = treated as 00
density  in  8  spawn probability gate
note_valid  out  1  note_lanes holds an undelivered note
note_ready  in  1  consumer accepts when valid&ready
note_lanes  out  LANES  one bit per lane
note_count  out  CNT_W  accepted notes, saturating
drop_count  out  CNT_W  notes lost to backpressure, saturating
lfsr_state  out  LFSR_W  current LFSR value

Behaviour:
- Reset (RESET=0, async): lfsr=SEED, note_valid=0, note_lanes=0, note_count=0, drop_count=0. Assertion mid-operation discards any pending note immediately.
- LFSR: Fibonacci; next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}. Advances every cycle while enable=1; frozen while enable=0.
- seed_load=1 overrides advance: lfsr <= seed, or SEED if seed==0. The LFSR never holds 0.
- Spawn evaluation occurs when spawn_tick=1 && enable=1. It uses the pre-update lfsr value of that cycle, even when seed_load is also high. spawn_tick with enable=0 is ignored.
- idx = lfsr[IDX_W-1:0]; gate = lfsr[LFSR_W-1 -: 8].
- Density: the note is produced only if density==8'hFF or gate < density. density=0 means no notes.
- Lane mapping:
  - 00/11: idx<LANES gives onehot(idx); otherwise rest.
  - 10: idx>=LANES maps to onehot(idx-LANES); never rest.
  - 01: idx<LANES gives onehot(idx) | onehot((idx+1) mod LANES); otherwise rest.
- A rest or gated tick has no effect on outputs or counters.
- Output register:
  - A produced note loads if note_valid==0 or (note_valid && note_ready) that cycle. Then note_valid=1 and note_lanes is set on the next edge, giving 1-cycle latency.
  - Otherwise the note is dropped and drop_count increments, saturating at all-ones.
- While note_valid=1 and note_ready=0, note_lanes is held stable.
- On valid&ready with no new load: next cycle note_valid=0 and note_lanes=0.
- note_count increments on each valid&ready, saturating. Accept and load in the same cycle both happen: count+1 and the new note is presented.
- The pending note remains drainable while enable=0.

Test Plan:
- Reset, then 4 cycles with enable=1 and no load: lfsr_state = 0x0001, 0x0003, 0x0007, 0x000E, 0x001C; all other outputs 0.
- mode=00, density=FF, seed_load with seed=0x0003, then tick next cycle: one cycle later note_valid=1, note_lanes=5'b01000. With ready=1: note_count=1, then note_valid=0.
- mode=00, seed 0x0006, tick: no note (rest). mode=10, same seed: note_lanes=5'b00010.
- mode=01, seed 0x0004, tick: note_lanes=5'b10001. seed_load with seed=0: lfsr_state=SEED (0x0001).
- note_ready=0, mode=10, density=FF, two ticks: first note held, drop_count=1. Ready=1 with a simultaneous third tick: note_count=1 and the new note is presented without a gap.
- density=0, 20 ticks: note_valid stays 0. RESET pulsed low while note_valid=1: outputs clear asynchronously, and lfsr_state=0x0001 after release.
